// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                             |
// | Description : Shares one single-port memory between instruction fetch and  |
// |               the load/store stage. Data wins ties, and fetch is forced to |
// |               win after STARVE_MAX consecutive lost conflicts. One access  |
// |               is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.       |
// | Option      : define MEM_ARB_PERF_EN to enable the performance counters.   |
// |               Without it, the perf ports are tied to zero.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic [31:0]         perf_if_cnt,
  output logic [31:0]         perf_d_cnt,
  output logic [31:0]         perf_conflict_cnt
);

  localparam int         STRB_W       = DATA_W / 8;
  localparam logic [3:0] c_MEM_LAT    = 4'(MEM_LAT);
  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_grant;
  logic   w_pick_fetch;
  logic   w_capture;

  logic              r_is_fetch;
  logic              r_we;
  logic [3:0]        r_lat;
  logic [3:0]        r_starve;

  logic              r_if_gnt, r_d_gnt, r_if_rvalid, r_d_rvalid;
  logic              r_mem_en, r_mem_we, r_busy;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_if_rdata, r_d_rdata;
  logic [STRB_W-1:0] r_mem_wstrb;

  // Next-state decode and arbitration; requests only matter in IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_pick_fetch = 1'b0;
    case (r_state)
      IDLE: begin
        if (if_req || d_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ISSUE;
          if (if_req && d_req) begin
            w_pick_fetch = (r_starve == c_STARVE_MAX);
          end else begin
            w_pick_fetch = if_req;
          end
        end
      end
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (r_lat == 4'd1) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Last WAIT cycle: mem_rdata is valid and gets captured into the winner's rdata.
  assign w_capture = (r_state == WAIT) && (r_lat == 4'd1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Winner bookkeeping, latency countdown and fetch starvation tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_fetch <= 1'b0;
      r_we       <= 1'b0;
      r_lat      <= 4'd0;
      r_starve   <= 4'd0;
    end else begin
      if (w_grant) begin
        r_is_fetch <= w_pick_fetch;
        r_we       <= !w_pick_fetch && d_we;
        if (w_pick_fetch) begin
          r_starve <= 4'd0;
        end else if (if_req && (r_starve != c_STARVE_MAX)) begin
          r_starve <= r_starve + 4'd1;
        end
      end
      if (r_state == ISSUE)     r_lat <= c_MEM_LAT;
      else if (r_state == WAIT) r_lat <= r_lat - 4'd1;
    end
  end

  // Registered outputs; the mem_* registers double as the latched request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_gnt    <= w_grant && w_pick_fetch;
      r_d_gnt     <= w_grant && !w_pick_fetch;
      r_mem_en    <= w_grant;
      r_mem_we    <= w_grant && !w_pick_fetch && d_we;
      r_mem_addr  <= w_grant ? (w_pick_fetch ? if_addr : d_addr) : '0;
      r_mem_wdata <= (w_grant && !w_pick_fetch) ? d_wdata : '0;
      r_mem_wstrb <= (w_grant && !w_pick_fetch) ? d_wstrb : '0;
      r_if_rvalid <= w_capture && r_is_fetch;
      r_d_rvalid  <= w_capture && !r_is_fetch;
      r_busy      <= (w_state_nxt != IDLE);
      if (w_capture && r_is_fetch)  r_if_rdata <= mem_rdata;
      if (w_capture && !r_is_fetch) r_d_rdata  <= r_we ? '0 : mem_rdata;
    end
  end

  assign if_gnt    = r_if_gnt;
  assign d_gnt     = r_d_gnt;
  assign if_rvalid = r_if_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign busy      = r_busy;

`ifdef MEM_ARB_PERF_EN
  logic        w_conflict;
  logic [31:0] r_perf_if, r_perf_d, r_perf_cf;

  assign w_conflict = (r_state == IDLE) && if_req && d_req;

  // Grant and conflict counters, wrapping at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_if <= 32'd0;
      r_perf_d  <= 32'd0;
      r_perf_cf <= 32'd0;
    end else begin
      if (w_grant && w_pick_fetch)  r_perf_if <= r_perf_if + 32'd1;
      if (w_grant && !w_pick_fetch) r_perf_d  <= r_perf_d + 32'd1;
      if (w_conflict)               r_perf_cf <= r_perf_cf + 32'd1;
    end
  end

  assign perf_if_cnt       = r_perf_if;
  assign perf_d_cnt        = r_perf_d;
  assign perf_conflict_cnt = r_perf_cf;
`else
  assign perf_if_cnt       = 32'd0;
  assign perf_d_cnt        = 32'd0;
  assign perf_conflict_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_port_arbiter                                          |
// | Description : Randomized bench for mem_port_arbiter. A transaction-level   |
// |               model predicts, per clock edge, grants, memory strobes,      |
// |               responses and read data from the arbitration rules.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 1;
  localparam int STARVE_MAX = 4;
  localparam int STRB_W     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, d_req, d_we;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic              if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [DATA_W-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [31:0]       perf_if_cnt, perf_d_cnt, perf_conflict_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy),
    .perf_if_cnt(perf_if_cnt), .perf_d_cnt(perf_d_cnt), .perf_conflict_cnt(perf_conflict_cnt)
  );

  // Memory array with MEM_LAT read latency; junk on the bus when no read is due.
  logic [31:0] env_mem [0:255];
  logic [31:0] rd_pipe [0:MEM_LAT-1];
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  always @(posedge clk) begin
    if (mem_en && mem_we)
      for (int b = 0; b < STRB_W; b++)
        if (mem_wstrb[b]) env_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    rd_pipe[0] <= (mem_en && !mem_we) ? env_mem[mem_addr[9:2]] : $urandom;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Reference model state: one transaction at a time, decided at edge t_k.
  logic [31:0] ref_mem [0:255];
  bit          act, t_fetch, t_we;
  int          t_k, free_at, starve, cur_e;
  logic [31:0] t_addr, t_wdata, t_rd, exp_if_rdata, exp_d_rdata;
  logic [3:0]  t_strb;
  int          n_if, n_d, n_cf;
  bit          rnd, hold_both;
  logic [9:0]  order;
  int          n_order;
  int          n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // One clock: update the model for the edge just taken, compare, then drive.
  task automatic step();
    int  e;
    bit  just_if, just_d, in_issue;
    @(negedge clk);
    e     = edge_n;
    cur_e = e;
    if (rst) begin
      act = 0; starve = 0; free_at = e + 1;
      exp_if_rdata = '0; exp_d_rdata = '0;
      n_if = 0; n_d = 0; n_cf = 0;
    end else if (e >= free_at && (if_req || d_req)) begin
      act = 1; t_k = e; free_at = e + MEM_LAT + 3;
      if (if_req && d_req) begin
        n_cf++;
        t_fetch = (starve == STARVE_MAX);
      end else begin
        t_fetch = if_req;
      end
      if (t_fetch) begin
        starve = 0; n_if++;
        t_we = 0; t_addr = if_addr; t_wdata = '0; t_strb = '0;
      end else begin
        if (if_req) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
        n_d++;
        t_we = d_we; t_addr = d_addr; t_wdata = d_wdata; t_strb = d_wstrb;
      end
      if (t_we) begin
        for (int b = 0; b < STRB_W; b++)
          if (t_strb[b]) ref_mem[t_addr[9:2]][8*b +: 8] = t_wdata[8*b +: 8];
        t_rd = '0;
      end else begin
        t_rd = ref_mem[t_addr[9:2]];
      end
    end
    if (act && e == t_k + MEM_LAT + 1) begin
      if (t_fetch) exp_if_rdata = t_rd;
      else         exp_d_rdata  = t_rd;
    end

    in_issue = act && (e == t_k);
    chk("if_gnt",    if_gnt,    in_issue && t_fetch);
    chk("d_gnt",     d_gnt,     in_issue && !t_fetch);
    chk("mem_en",    mem_en,    in_issue);
    chk("if_rvalid", if_rvalid, act && (e == t_k + MEM_LAT + 1) && t_fetch);
    chk("d_rvalid",  d_rvalid,  act && (e == t_k + MEM_LAT + 1) && !t_fetch);
    chk("busy",      busy,      act && (e >= t_k) && (e <= t_k + MEM_LAT + 1));
    chk("if_rdata",  if_rdata,  exp_if_rdata);
    chk("d_rdata",   d_rdata,   exp_d_rdata);
    if (in_issue) begin
      chk("mem_we",    mem_we,    t_we);
      chk("mem_addr",  mem_addr,  t_addr);
      chk("mem_wstrb", mem_wstrb, t_strb);
      if (!t_fetch) chk("mem_wdata", mem_wdata, t_wdata);
    end
    if (hold_both && (if_gnt || d_gnt)) begin
      order = {order[8:0], if_gnt};
      n_order++;
    end

    just_if = in_issue && t_fetch;
    just_d  = in_issue && !t_fetch;
    if (just_if) if_req = 0;
    if (just_d)  d_req  = 0;
    if (hold_both) begin
      if (!if_req && !just_if) if_req = 1;
      if (!d_req && !just_d)   d_req  = 1;
    end
    if (rnd) begin
      if (!if_req && !just_if && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (!d_req && !just_d && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = $urandom_range(0, 1) == 1; d_addr = $urandom;
        d_wdata = $urandom; d_wstrb = 4'($urandom_range(1, 15));
      end
    end
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    rnd = 0; hold_both = 0; order = '0; n_order = 0;
    act = 0; t_k = 0; starve = 0; free_at = 0; cur_e = 0;
    t_fetch = 0; t_we = 0; t_addr = '0; t_wdata = '0; t_rd = '0; t_strb = '0;
    exp_if_rdata = '0; exp_d_rdata = '0; n_if = 0; n_d = 0; n_cf = 0;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    env_mem[8'h11] = 32'h0010_0193;
    ref_mem[8'h11] = 32'h0010_0193;

    repeat (3) step();
    rst = 1'b0;

    // Single fetch from 0x44.
    if_req = 1; if_addr = 32'h44;
    repeat (MEM_LAT + 4) step();
    chk("fetch_0x44", if_rdata, 32'h0010_0193);

    // Full-word store then load back at 0x100.
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    repeat (MEM_LAT + 4) step();
    d_req = 1; d_we = 0; d_addr = 32'h100;
    repeat (MEM_LAT + 4) step();
    chk("load_0x100", d_rdata, 32'hDEAD_BEEF);

    // Single-byte store, then read the word back.
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h0000_AB00; d_wstrb = 4'h2;
    repeat (MEM_LAT + 4) step();
    d_req = 1; d_we = 0; d_addr = 32'h200;
    repeat (MEM_LAT + 4) step();

    // Continuous contention: expect D,D,D,D,F,D,D,D,D,F.
    hold_both = 1; if_req = 1; if_addr = 32'h44;
    d_req = 1; d_we = 0; d_addr = 32'h100;
    guard = 0;
    while (n_order < 10 && guard < 200) begin
      step();
      guard++;
    end
    hold_both = 0;
    chk("grant_order", order, 10'b00001_00001);

    // Random traffic, then drain.
    rnd = 1;
    repeat (600) step();
    rnd = 0;
    repeat (20) step();

    // Reset while a load sits in WAIT.
    d_req = 1; d_we = 0; d_addr = 32'h100;
    guard = 0;
    while (!(act && cur_e == t_k + 1) && guard < 20) begin
      step();
      guard++;
    end
    chk("reached_wait", act && cur_e == t_k + 1, 1);
    rst = 1'b1;
    #1;
    chk("rst_busy",     busy,      0);
    chk("rst_d_rdata",  d_rdata,   0);
    chk("rst_if_rdata", if_rdata,  0);
    chk("rst_mem_en",   mem_en,    0);
    chk("rst_d_rvalid", d_rvalid,  0);
    chk("rst_perf_d",   perf_d_cnt, 0);
    repeat (2) step();
    rst = 1'b0;
    repeat (6) step();
    d_req = 1; d_we = 0; d_addr = 32'h44;
    repeat (MEM_LAT + 4) step();
    chk("post_rst_load", d_rdata, 32'h0010_0193);

`ifdef MEM_ARB_PERF_EN
    chk("perf_if",   perf_if_cnt,       n_if);
    chk("perf_d",    perf_d_cnt,        n_d);
    chk("perf_conf", perf_conflict_cnt, n_cf);
`else
    chk("perf_if",   perf_if_cnt,       0);
    chk("perf_d",    perf_d_cnt,        0);
    chk("perf_conf", perf_conflict_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the core's single-port unified memory between the instruction-fetch stage and the data (load/store) stage of the pipelined core. Accepts one request per requester and arbitrates: data has priority, with starvation protection for fetch. Issues exactly one memory transaction at a time and returns read data or a write acknowledgement to the winner. Sits between Core pipeline stages and the memory array.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 1, cycles from mem_en cycle to mem_rdata valid (legal 1..8)
STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win (legal 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request, held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle fetch grant pulse
if_rvalid  out  1  one-cycle fetch data valid
if_rdata  out  DATA_W  fetched word
d_req  in  1  data request, held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_wstrb  in  DATA_W/8  byte enables for stores
d_gnt  out  1  one-cycle data grant pulse
d_rvalid  out  1  one-cycle load data / store ack
d_rdata  out  DATA_W  load data (0 for stores)
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data
busy  out  1  high in any state except IDLE
perf_if_cnt, perf_d_cnt, perf_conflict_cnt  out  32 each  performance counters (see Optional Feature)

Behaviour:
- Clock clk; reset rst is asynchronous and active-high. All outputs registered; reset value 0 for every output; state = IDLE, starve_cnt = 0, latency counter = 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: requests sampled at rising edge. None -> stay. Else pick winner, latch address/we/wdata/wstrb, go ISSUE. Requests ignored in all other states.
- Arbitration: only d_req -> data; only if_req -> fetch; both -> data unless starve_cnt == STARVE_MAX, then fetch. starve_cnt increments when both request and data wins; cleared on any fetch grant; saturates at STARVE_MAX.
- ISSUE (1 cycle): mem_en=1, mem_* driven from latched values (fetch: mem_we=0, mem_wstrb=0); winner's gnt=1. Load counter with MEM_LAT; go WAIT.
- WAIT: decrement each cycle; the edge ending the cycle MEM_LAT after ISSUE captures mem_rdata into winner's rdata (0 for stores); go RESP.
- RESP (1 cycle): winner's rvalid=1, rdata stable; go IDLE. rdata holds until next capture.
- Latency: req high at edge E -> gnt in cycle E+1 -> rvalid in cycle E+2+MEM_LAT (MEM_LAT=1: 3 cycles). Back-to-back throughput: one transaction per MEM_LAT+3 cycles.
- Requester must drop req in the cycle after gnt; req high in next IDLE is a new request.
- mem_en, gnt, rvalid never asserted outside ISSUE/ISSUE/RESP respectively; if_* and d_* never asserted in the same cycle.
- Reset mid-transaction: in-flight access abandoned, no rvalid, starve_cnt cleared.

Optional Feature:
MEM_ARB_PERF_EN: when defined, perf_if_cnt/perf_d_cnt increment on each if_gnt/d_gnt, perf_conflict_cnt increments on each IDLE arbitration with both requests; 32-bit wrapping, cleared by rst. When undefined, ports remain and are tied to 0; no counter logic.

Test Plan:
- Single fetch: if_req=1, if_addr=0x44, mem holds 0x00100193 -> if_gnt 1 cycle later, mem_en/mem_addr=0x44, if_rvalid with if_rdata=0x00100193 3 cycles after request (MEM_LAT=1).
- Store then load: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=0xF -> mem_we=1, d_rvalid with d_rdata=0; then load 0x100 -> d_rdata=0xDEADBEEF.
- Contention: if_req and d_req held continuously, STARVE_MAX=4 -> grant order D,D,D,D,F,D,D,D,D,F; no simultaneous gnt.
- Byte store: d_wstrb=0x2, d_wdata=0x0000AB00 -> mem_wstrb=0x2 in ISSUE cycle, mem_we=1.
- Reset in WAIT: assert rst during WAIT of a load -> all outputs 0 immediately, no rvalid afterwards, next request served normally.
- MEM_LAT=3 with MEM_ARB_PERF_EN: 2 fetches + 1 conflict -> rvalid 5 cycles after req; perf_if_cnt=2, perf_conflict_cnt=1.
